// File: rtl/puf_pkg.sv
// Shared types and limits for the PUF sampling path (sequencer and majority voter).
package puf_pkg;
    localparam int PUF_SUM_MAX = 63;
    localparam int PUF_WIDTH   = 128;

    typedef enum logic [3:0] {
        IDLE, CLEAR, EXCITE, SETTLE, SAMPLE, GAP, VOTE, WAIT_DONE, HOLD, CLEAR_END
    } seq_state_e;

    // Majority threshold the top level hands to the voter.
    function automatic int vote_threshold(input int num_samples);
        return num_samples / 2 + 1;
    endfunction
endpackage

// File: rtl/puf_sample_sequencer_if.sv
// Request/response and voter-control bundle between the sequencer and its neighbours.
interface puf_sample_sequencer_if #(parameter int WIDTH = puf_pkg::PUF_WIDTH);
    logic             start;
    logic             abort;
    logic             busy;
    logic             puf_en;
    logic             v_ready;
    logic             v_vote;
    logic             v_clear;
    logic             v_done;
    logic [WIDTH-1:0] v_data;
    logic [WIDTH-1:0] resp_data;
    logic             resp_valid;
    logic             resp_ack;
    logic             err_timeout;

    modport master (
        input  start, abort, v_done, v_data, resp_ack,
        output busy, puf_en, v_ready, v_vote, v_clear, resp_data, resp_valid, err_timeout
    );
    modport slave (
        output start, abort, v_done, v_data, resp_ack,
        input  busy, puf_en, v_ready, v_vote, v_clear, resp_data, resp_valid, err_timeout
    );
endinterface

// File: rtl/puf_sample_sequencer.sv
// Drives the PUF excite/settle/sample loop and all voter strobes for one voted response.
module puf_sample_sequencer
    import puf_pkg::*;
#(
    parameter int WIDTH         = PUF_WIDTH,
    parameter int NUM_SAMPLES   = 9,
    parameter int SETTLE_CYCLES = 16,
    parameter int DONE_TIMEOUT  = 8
) (
    input logic                    clk,
    input logic                    rst,
    puf_sample_sequencer_if.master seq_if
);
    localparam int SW = $clog2(SETTLE_CYCLES) + 1;
    localparam int NW = $clog2(NUM_SAMPLES) + 1;
    localparam int TW = $clog2(DONE_TIMEOUT) + 1;

    // EXCITE already counts toward the settle time, so SETTLE itself runs one cycle
    // short of SETTLE_CYCLES (but never less than one cycle).
    localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYCLES >= 2) ? SETTLE_CYCLES - 2 : 0);
    localparam logic [NW-1:0] SAMPLE_LAST = NW'(NUM_SAMPLES - 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(DONE_TIMEOUT - 1);

    if (NUM_SAMPLES > PUF_SUM_MAX || NUM_SAMPLES < 1) begin : g_bad_ns
        $error("NUM_SAMPLES must be within 1..63");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("SETTLE_CYCLES must be >= 1");
    end
    if (DONE_TIMEOUT < 2) begin : g_bad_to
        $error("DONE_TIMEOUT must be >= 2");
    end

    seq_state_e       state_q;
    logic [SW-1:0]    settle_cnt_q;
    logic [NW-1:0]    sample_cnt_q;
    logic [TW-1:0]    to_cnt_q;
    logic             busy_q, puf_en_q, v_ready_q, v_vote_q, v_clear_q;
    logic             resp_valid_q, err_timeout_q;
    logic [WIDTH-1:0] resp_data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            settle_cnt_q  <= '0;
            sample_cnt_q  <= '0;
            to_cnt_q      <= '0;
            busy_q        <= 1'b0;
            puf_en_q      <= 1'b0;
            v_ready_q     <= 1'b0;
            v_vote_q      <= 1'b0;
            v_clear_q     <= 1'b0;
            resp_valid_q  <= 1'b0;
            err_timeout_q <= 1'b0;
            resp_data_q   <= '0;
        end else begin
            // Strobes are single-cycle; at most one is raised per transition.
            v_ready_q <= 1'b0;
            v_vote_q  <= 1'b0;
            v_clear_q <= 1'b0;
            if (seq_if.abort && state_q != IDLE && state_q != CLEAR_END) begin
                state_q      <= CLEAR_END;
                puf_en_q     <= 1'b0;
                resp_valid_q <= 1'b0;
                v_clear_q    <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: if (seq_if.start) begin
                        state_q       <= CLEAR;
                        busy_q        <= 1'b1;
                        v_clear_q     <= 1'b1;
                        err_timeout_q <= 1'b0;
                        sample_cnt_q  <= '0;
                    end
                    CLEAR, GAP: begin
                        state_q      <= EXCITE;
                        puf_en_q     <= 1'b1;
                        settle_cnt_q <= '0;
                    end
                    EXCITE: begin
                        state_q      <= SETTLE;
                        settle_cnt_q <= '0;
                    end
                    SETTLE: begin
                        if (settle_cnt_q >= SETTLE_LAST) begin
                            state_q   <= SAMPLE;
                            v_ready_q <= 1'b1;
                        end else begin
                            settle_cnt_q <= settle_cnt_q + 1'b1;
                        end
                    end
                    SAMPLE: begin
                        puf_en_q     <= 1'b0;
                        sample_cnt_q <= sample_cnt_q + 1'b1;
                        if (sample_cnt_q == SAMPLE_LAST) begin
                            state_q  <= VOTE;
                            v_vote_q <= 1'b1;
                        end else begin
                            state_q <= GAP;
                        end
                    end
                    VOTE: begin
                        state_q  <= WAIT_DONE;
                        to_cnt_q <= '0;
                    end
                    WAIT_DONE: begin
                        if (seq_if.v_done) begin
                            state_q      <= HOLD;
                            resp_data_q  <= seq_if.v_data;
                            resp_valid_q <= 1'b1;
                        end else if (to_cnt_q == TO_LAST) begin
                            state_q       <= CLEAR_END;
                            err_timeout_q <= 1'b1;
                            v_clear_q     <= 1'b1;
                        end else begin
                            to_cnt_q <= to_cnt_q + 1'b1;
                        end
                    end
                    HOLD: if (seq_if.resp_ack) begin
                        state_q      <= CLEAR_END;
                        resp_valid_q <= 1'b0;
                        v_clear_q    <= 1'b1;
                    end
                    CLEAR_END: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign seq_if.busy        = busy_q;
    assign seq_if.puf_en      = puf_en_q;
    assign seq_if.v_ready     = v_ready_q;
    assign seq_if.v_vote      = v_vote_q;
    assign seq_if.v_clear     = v_clear_q;
    assign seq_if.resp_data   = resp_data_q;
    assign seq_if.resp_valid  = resp_valid_q;
    assign seq_if.err_timeout = err_timeout_q;
endmodule
